// File: rtl/axis_phase_trigger_tagger.sv
// Tags each accepted ADC beat with the phase accumulator value and emits {phase, data},
// with a sticky level-crossing trigger aligned to the beat that caused it.
module axis_phase_trigger_tagger #(
    parameter int AXIS_TDATA_WIDTH       = 32,
    parameter int AXIS_TDATA_PHASE_WIDTH = 32,
    parameter int TRIG_WIDTH             = 16,
    parameter int CNTR_WIDTH             = 32
) (
    input  logic                                               aclk,
    input  logic                                               areset,
    input  logic [AXIS_TDATA_PHASE_WIDTH-1:0]                  cfg_phase_inc,
    input  logic [TRIG_WIDTH-1:0]                              cfg_level,
    input  logic                                               cfg_edge,
    input  logic [CNTR_WIDTH-1:0]                              cfg_holdoff,
    input  logic                                               arm,
    input  logic                                               phase_clr,
    output logic                                               trigger,
    output logic                                               armed,
    output logic                                               s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]                        s_axis_tdata,
    input  logic                                               s_axis_tvalid,
    input  logic                                               m_axis_tready,
    output logic [AXIS_TDATA_WIDTH+AXIS_TDATA_PHASE_WIDTH-1:0] m_axis_tdata,
    output logic                                               m_axis_tvalid
);

    typedef enum logic [1:0] {
        IDLE,
        HOLDOFF,
        ARMED,
        TRIGGERED
    } state_t;

    state_t                            state;
    state_t                            state_next;
    logic [AXIS_TDATA_PHASE_WIDTH-1:0] acc;
    logic [AXIS_TDATA_PHASE_WIDTH-1:0] tag;
    logic [CNTR_WIDTH-1:0]             holdoff_cnt;
    logic signed [TRIG_WIDTH-1:0]      sample;
    logic signed [TRIG_WIDTH-1:0]      level;
    logic signed [TRIG_WIDTH-1:0]      prev;
    logic                              prev_valid;
    logic                              accept;
    logic                              crossing;

    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign sample        = s_axis_tdata[TRIG_WIDTH-1:0];
    assign level         = cfg_level;
    assign tag           = phase_clr ? '0 : acc;
    assign armed         = (state == HOLDOFF) | (state == ARMED);

    always_comb begin
        crossing = 1'b0;
        if (prev_valid) begin
            if (cfg_edge) begin
                crossing = (prev < level) && (sample >= level);
            end else begin
                crossing = (prev > level) && (sample <= level);
            end
        end
    end

    // arm overrides everything, including a crossing accepted in the same cycle
    always_comb begin
        state_next = state;
        if (arm) begin
            state_next = HOLDOFF;
        end else begin
            case (state)
                IDLE:      state_next = IDLE;
                HOLDOFF:   if (holdoff_cnt == cfg_holdoff) state_next = ARMED;
                ARMED:     if (accept && crossing) state_next = TRIGGERED;
                TRIGGERED: state_next = TRIGGERED;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            trigger     <= 1'b0;
            holdoff_cnt <= '0;
        end else begin
            state   <= state_next;
            trigger <= (state_next == TRIGGERED);
            if (arm) begin
                holdoff_cnt <= '0;
            end else if ((state == HOLDOFF) && accept && (holdoff_cnt != cfg_holdoff)) begin
                holdoff_cnt <= holdoff_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else begin
            if (accept) begin
                prev <= sample;
            end
            if (arm) begin
                prev_valid <= 1'b0;
            end else if (accept) begin
                prev_valid <= 1'b1;
            end
        end
    end

    // Output stage and accumulator share the accept qualifier so the tag is always pre-increment
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (accept) begin
                m_axis_tdata  <= {tag, s_axis_tdata};
                m_axis_tvalid <= 1'b1;
                acc           <= tag + cfg_phase_inc;
            end else begin
                if (m_axis_tready) begin
                    m_axis_tvalid <= 1'b0;
                end
                if (phase_clr) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule
